// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle of uart_rx_param; PARITY_ERR exists only when
// UART_RX_PARITY_EN is defined.
// DATA/PARITY_ERR are stable while VALID=1; a word transfers on a cycle with VALID&&READY.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] DATA;
    logic                 VALID;
    logic                 READY;
    logic                 FRAME_ERR;
    logic                 OVERRUN;
`ifdef UART_RX_PARITY_EN
    logic                 PARITY_ERR;
`endif

    modport master (
        output DATA, VALID, FRAME_ERR, OVERRUN,
`ifdef UART_RX_PARITY_EN
        output PARITY_ERR,
`endif
        input  READY
    );

    modport slave (
        input  DATA, VALID, FRAME_ERR, OVERRUN,
`ifdef UART_RX_PARITY_EN
        input  PARITY_ERR,
`endif
        output READY
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with glitch rejection, framing/overrun pulses and a
// VALID/READY output. Optional parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             UART_RXD,
    uart_rx_param_if.master  rx,
    output logic [2:0]       dbg_state
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1'b1) begin : g_bad_po
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd5
`endif
    } state_t;

    state_t               state, state_n;
    logic                 rxd_meta, rxd_s;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 cnt_clr, shift_en, stop_adv, frame_ok, frame_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_en, par_q;
`endif

    assign dbg_state = state;

    // UART_RXD is asynchronous; idle-high reset value avoids a false start.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= UART_RXD;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_adv  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            S_IDLE: if (!rxd_s) begin
                state_n = S_START;
                cnt_clr = 1'b1;
            end
            S_START: if (cnt == HALF_M1) begin
                cnt_clr = 1'b1;
                state_n = rxd_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt == BIT_M1) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (cnt == BIT_M1) begin
                cnt_clr = 1'b1;
                par_en  = 1'b1;
                state_n = S_STOP;
            end
`endif
            S_STOP: if (cnt == BIT_M1) begin
                cnt_clr = 1'b1;
                if (!rxd_s) begin
                    frame_bad = 1'b1;
                    state_n   = S_BREAK;
                end else if (stop_idx == STOP_LAST) begin
                    frame_ok = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    stop_adv = 1'b1;
                end
            end
            S_BREAK: if (rxd_s) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
        end else begin
            if (cnt_clr || state == S_IDLE || state == S_BREAK) cnt <= '0;
            else                                                cnt <= cnt + 1'b1;
            if (state == S_IDLE) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
            end else begin
                if (shift_en) bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
                if (stop_adv) stop_idx <= 1'b1;
            end
            // LSB arrives first, so shifting right leaves it at bit 0.
            if (shift_en) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)      par_q <= 1'b0;
        else if (par_en) par_q <= (^{shreg, rxd_s}) ^ PARITY_ODD;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx.DATA      <= '0;
            rx.VALID     <= 1'b0;
            rx.FRAME_ERR <= 1'b0;
            rx.OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx.PARITY_ERR <= 1'b0;
`endif
        end else begin
            rx.FRAME_ERR <= frame_bad;
            rx.OVERRUN   <= 1'b0;
            if (rx.VALID && rx.READY) rx.VALID <= 1'b0;
            // A word still held un-consumed wins over the new one.
            if (frame_ok) begin
                if (!rx.VALID || rx.READY) begin
                    rx.DATA  <= shreg;
                    rx.VALID <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    rx.PARITY_ERR <= par_q;
`endif
                end else begin
                    rx.OVERRUN <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: vector table, random frames against a
// frame-level model, and hand sequences for glitch, break, overrun and reset.
module tb_uart_rx_param;
    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam bit PODD = 1'b0;
    localparam int W    = DB + 1;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       UART_RXD;
    logic [2:0] dbg_state;
    logic       pe_now;

    uart_rx_param_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .UART_RXD(UART_RXD), .rx(rx_if.master),
        .dbg_state(dbg_state)
    );

`ifdef UART_RX_PARITY_EN
    assign pe_now = rx_if.PARITY_ERR;
`else
    assign pe_now = 1'b0;
`endif

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, valid_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Parity bit that makes the frame correct for the selected sense.
    function automatic logic good_par(input logic [DB-1:0] d);
        return ((($countones(d) % 2) == 1) != PODD);
    endfunction

    function automatic logic exp_pe(input logic [DB-1:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
        return ((($countones({d, p}) % 2) == 1) != PODD);
`else
        return (d != d) && p;
`endif
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stop_val);
        UART_RXD = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            UART_RXD = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        UART_RXD = p;
        tick(CPB);
`endif
        for (int s = 0; s < SB; s++) begin
            UART_RXD = stop_val;
            tick(CPB);
        end
    endtask

    task automatic send_good(input logic [DB-1:0] d);
        exp_q.push_back({1'b0, d});
        send_frame(d, good_par(d), 1'b1);
        UART_RXD = 1'b1;
    endtask

    // Consumer-side monitor: counts pulses and scores every transferred word.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (rx_if.VALID)     valid_cyc++;
            if (rx_if.FRAME_ERR) ferr_cnt++;
            if (rx_if.OVERRUN)   ovr_cnt++;
            if (rx_if.VALID && rx_if.READY) begin
                acc_cnt++;
                last_acc = {pe_now, rx_if.DATA};
                if (exp_q.size() == 0) check("unexpected_word", 32'(exp_q.size()), 32'd1);
                else                   check("rx_word", 32'(last_acc), 32'(exp_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic [DB-1:0] data;
        logic          stop;
        int            exp_valid;
        int            exp_ferr;
    } vec_t;

    vec_t vecs[6];
    int a0, f0, o0, v0, n_bad;
    logic [DB-1:0] rd;
    logic          rs, rp;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'hA3, 1'b1, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h0F, 1'b0, 0, 1};
        vecs[5] = '{8'h81, 1'b1, 1, 0};

        RST_N = 1'b0;
        UART_RXD = 1'b1;
        rx_if.READY = 1'b1;
        tick(3);
        check("rst_valid", 32'(rx_if.VALID), 32'd0);
        check("rst_data", 32'(rx_if.DATA), 32'd0);
        check("rst_frame_err", 32'(rx_if.FRAME_ERR), 32'd0);
        check("rst_overrun", 32'(rx_if.OVERRUN), 32'd0);
        check("rst_parity_err", 32'(pe_now), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        RST_N = 1'b1;
        tick(4);

        for (int i = 0; i < 6; i++) begin
            a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cyc;
            if (vecs[i].exp_valid == 1) exp_q.push_back({1'b0, vecs[i].data});
            send_frame(vecs[i].data, good_par(vecs[i].data), vecs[i].stop);
            UART_RXD = 1'b1;
            tick(2 * CPB);
            check("vec_accepts", 32'(acc_cnt - a0), 32'(vecs[i].exp_valid));
            check("vec_valid_cycles", 32'(valid_cyc - v0), 32'(vecs[i].exp_valid));
            check("vec_frame_err", 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check("vec_overrun", 32'(ovr_cnt - o0), 32'd0);
        end

        // Start-bit glitch shorter than half a bit, then a real frame.
        a0 = acc_cnt; f0 = ferr_cnt;
        UART_RXD = 1'b0;
        tick(4);
        UART_RXD = 1'b1;
        tick(2 * CPB);
        check("glitch_accepts", 32'(acc_cnt - a0), 32'd0);
        check("glitch_frame_err", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_state", 32'(dbg_state), 32'd0);
        send_good(8'hA3);
        tick(2 * CPB);
        check("post_glitch_accepts", 32'(acc_cnt - a0), 32'd1);

        // Bad stop then line held low: exactly one framing error.
        a0 = acc_cnt; f0 = ferr_cnt;
        send_frame(8'h0F, good_par(8'h0F), 1'b0);
        tick(3 * CPB);
        UART_RXD = 1'b1;
        tick(2 * CPB);
        check("break_frame_err", 32'(ferr_cnt - f0), 32'd1);
        check("break_accepts", 32'(acc_cnt - a0), 32'd0);
        send_good(8'h81);
        tick(2 * CPB);
        check("post_break_accepts", 32'(acc_cnt - a0), 32'd1);
        check("post_break_data", 32'(last_acc), 32'h081);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back({1'b0, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1);
        UART_RXD = 1'b1;
        tick(2 * CPB);
        check("parity_ok_word", 32'(last_acc), 32'h007);
        exp_q.push_back({1'b1, 8'h07});
        send_frame(8'h07, 1'b0, 1'b1);
        UART_RXD = 1'b1;
        tick(2 * CPB);
        check("parity_err_word", 32'(last_acc), 32'h107);
`endif

        // Random frames against the frame-level model.
        f0 = ferr_cnt; n_bad = 0;
        for (int k = 0; k < 24; k++) begin
            rd = DB'($urandom_range(0, (1 << DB) - 1));
            rs = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            rp = 1'($urandom_range(0, 1));
`else
            rp = good_par(rd);
`endif
            if (rs) exp_q.push_back({exp_pe(rd, rp), rd});
            else    n_bad++;
            send_frame(rd, rp, rs);
            UART_RXD = 1'b1;
            tick($urandom_range(4, 12));
        end
        tick(2 * CPB);
        check("rand_frame_err", 32'(ferr_cnt - f0), 32'(n_bad));
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

        // Slow consumer: second word dropped with one OVERRUN pulse.
        rx_if.READY = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt;
        send_good(8'h12);
        tick(8);
        send_frame(8'h34, good_par(8'h34), 1'b1);
        UART_RXD = 1'b1;
        tick(2 * CPB);
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_accepts", 32'(acc_cnt - a0), 32'd0);
        check("ovr_valid_held", 32'(rx_if.VALID), 32'd1);
        check("ovr_data_held", 32'(rx_if.DATA), 32'h12);
        rx_if.READY = 1'b1;
        tick(1);
        check("ovr_valid_drop", 32'(rx_if.VALID), 32'd0);
        check("ovr_late_accept", 32'(acc_cnt - a0), 32'd1);

        // Reset during data bit 4.
        tick(CPB);
        UART_RXD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            UART_RXD = rd[i];
            tick(CPB);
        end
        UART_RXD = 1'b0;
        tick(CPB / 2);
        RST_N = 1'b0;
        #1;
        check("midrst_valid", 32'(rx_if.VALID), 32'd0);
        check("midrst_data", 32'(rx_if.DATA), 32'd0);
        check("midrst_frame_err", 32'(rx_if.FRAME_ERR), 32'd0);
        check("midrst_overrun", 32'(rx_if.OVERRUN), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        UART_RXD = 1'b1;
        tick(3);
        RST_N = 1'b1;
        a0 = acc_cnt; f0 = ferr_cnt;
        tick(2 * CPB);
        check("postrst_quiet_accepts", 32'(acc_cnt - a0), 32'd0);
        check("postrst_quiet_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_good(8'hC3);
        tick(2 * CPB);
        check("postrst_accepts", 32'(acc_cnt - a0), 32'd1);
        check("postrst_data", 32'(last_acc), 32'h0C3);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
